// File: rtl/sd_mag_scanner_pkg.sv
// Shared types and helpers for the sigma-delta magnitude scanner.
package sd_pkg;

   localparam int MAX_NCH = 16;

   typedef enum logic [2:0] {
      SD_IDLE,
      SD_CLEAR,
      SD_SETTLE,
      SD_CAPTURE,
      SD_HOLD
   } sd_scan_state_t;

   function automatic int ch_w(input int nch);
      return (nch < 2) ? 1 : $clog2(nch);
   endfunction

   // First set mask bit strictly after cur, wrapping; returns cur when no other bit is set.
   function automatic int find_next_ch(input logic [MAX_NCH-1:0] mask, input int cur, input int nch);
      int res;
      int idx;
      logic found;
      res   = cur;
      found = 1'b0;
      for (int i = 1; i <= MAX_NCH; i++) begin
         idx = cur + i;
         if (idx >= nch) idx = idx - nch;
         if (!found && (i <= nch) && ((mask & (MAX_NCH'(1) << idx)) != '0)) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sd_mag_scanner_if.sv
// Control, estimator and result signals of the scanner; master is the scanner side.
interface sd_mag_scanner_if #(
   parameter int NCH   = 4,
   parameter int WIDTH = 16,
   parameter int DIV_W = 8,
   parameter int SET_W = 16
) ();
   import sd_pkg::*;

   localparam int CH_W = ch_w(NCH);

   logic             start;
   logic             abort;
   logic             continuous;
   logic [NCH-1:0]   ch_mask;
   logic [DIV_W-1:0] div;
   logic [SET_W-1:0] settle;
   logic [NCH-1:0]   sd_in;
   logic             est_rst;
   logic             est_en;
   logic             est_in;
   logic [WIDTH-1:0] est_out;
   logic             res_valid;
   logic             res_ready;
   logic [CH_W-1:0]  res_ch;
   logic [WIDTH-1:0] res_mag;
   logic             busy;

   modport master (
      input  start, abort, continuous, ch_mask, div, settle, sd_in, est_out, res_ready,
      output est_rst, est_en, est_in, res_valid, res_ch, res_mag, busy
   );

   modport slave (
      output start, abort, continuous, ch_mask, div, settle, sd_in, est_out, res_ready,
      input  est_rst, est_en, est_in, res_valid, res_ch, res_mag, busy
   );

endinterface

// File: rtl/sd_mag_scanner_strobe_gen.sv
// Free-running divider: one-cycle strobe every i_div+1 cycles while i_run is high.
module sd_strobe_gen #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic             i_clear,
   input  logic             i_run,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_strobe
);

   logic [DIV_W-1:0] r_cnt;

   assign o_strobe = i_run && (r_cnt == i_div);

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= o_strobe ? '0 : r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/sd_mag_scanner.sv
// Scan controller: visits each masked sigma-delta channel, settles the shared estimator
// on it and hands the captured magnitude out on a valid/ready result port.
module sd_mag_scanner
   import sd_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int WIDTH = 16,
   parameter int DIV_W = 8,
   parameter int SET_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   sd_mag_scanner_if.master bus
);

   localparam int CH_W = ch_w(NCH);

   sd_scan_state_t   r_state;
   sd_scan_state_t   w_stateNext;
   logic [NCH-1:0]   r_mask;
   logic [CH_W-1:0]  r_curCh;
   logic [CH_W-1:0]  w_chNext;
   logic [DIV_W-1:0] r_div;
   logic [SET_W-1:0] r_settle;
   logic [SET_W-1:0] r_strobeCnt;
   logic [WIDTH-1:0] r_resMag;
   logic [CH_W-1:0]  r_resCh;
   logic             r_resValid;
   logic             w_strobe;
   logic             w_lastStrobe;
   logic             w_load;
   int               w_idleNext;
   int               w_holdNext;

   assign w_idleNext   = find_next_ch(MAX_NCH'(bus.ch_mask), NCH - 1, NCH);
   assign w_holdNext   = find_next_ch(MAX_NCH'(r_mask), int'(r_curCh), NCH);
   assign w_lastStrobe = w_strobe && (r_strobeCnt == r_settle - SET_W'(1));

   sd_strobe_gen #(.DIV_W(DIV_W)) u_strobe (
      .i_clk    (clk),
      .i_rstN   (rst_n),
      .i_clear  (r_state == SD_CLEAR),
      .i_run    (r_state == SD_SETTLE),
      .i_div    (r_div),
      .o_strobe (w_strobe)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= SD_IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext   = r_state;
      w_chNext      = r_curCh;
      w_load        = 1'b0;
      bus.est_rst   = (r_state == SD_IDLE) || (r_state == SD_CLEAR);
      bus.est_en    = w_strobe;
      bus.est_in    = (r_state == SD_IDLE) ? 1'b0 : bus.sd_in[r_curCh];
      bus.busy      = (r_state != SD_IDLE);
      bus.res_valid = r_resValid;
      bus.res_ch    = r_resCh;
      bus.res_mag   = r_resMag;
      case (r_state)
         SD_IDLE: begin
            if (bus.start && !bus.abort && (bus.ch_mask != '0)) begin
               w_stateNext = SD_CLEAR;
               w_chNext    = CH_W'(w_idleNext);
               w_load      = 1'b1;
            end
         end
         SD_CLEAR:   w_stateNext = SD_SETTLE;
         SD_SETTLE:  if (w_lastStrobe) w_stateNext = SD_CAPTURE;
         SD_CAPTURE: w_stateNext = SD_HOLD;
         SD_HOLD: begin
            // A result at or below the current channel means the pass is complete.
            if (r_resValid && bus.res_ready) begin
               if ((w_holdNext > int'(r_curCh)) || bus.continuous) begin
                  w_stateNext = SD_CLEAR;
                  w_chNext    = CH_W'(w_holdNext);
               end else begin
                  w_stateNext = SD_IDLE;
               end
            end
         end
         default: w_stateNext = SD_IDLE;
      endcase
      if (bus.abort) w_stateNext = SD_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask      <= '0;
         r_curCh     <= '0;
         r_div       <= '0;
         r_settle    <= SET_W'(1);
         r_strobeCnt <= '0;
      end else begin
         r_curCh <= w_chNext;
         if (w_load) r_mask <= bus.ch_mask;
         if (r_state == SD_CLEAR) begin
            r_div       <= bus.div;
            r_settle    <= (bus.settle == '0) ? SET_W'(1) : bus.settle;
            r_strobeCnt <= '0;
         end else if (w_strobe) begin
            r_strobeCnt <= r_strobeCnt + SET_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resValid <= 1'b0;
         r_resMag   <= '0;
         r_resCh    <= '0;
      end else if (bus.abort && (r_state != SD_IDLE)) begin
         r_resValid <= 1'b0;
      end else if (r_state == SD_CAPTURE) begin
         r_resValid <= 1'b1;
         r_resMag   <= bus.est_out;
         r_resCh    <= r_curCh;
      end else if ((r_state == SD_HOLD) && r_resValid && bus.res_ready) begin
         r_resValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_mag_scanner.sv
// Randomized bench for sd_mag_scanner; expected timing and results come from the
// closed-form scan schedule and a cycle-indexed estimator pattern.
module tb_sd_mag_scanner;

   localparam int NCH        = 4;
   localparam int WIDTH      = 16;
   localparam int DIV_W      = 8;
   localparam int SET_W      = 16;
   localparam int CYC_BUDGET = 300;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   nChecks = 0;
   int   nErrors = 0;

   sd_mag_scanner_if #(.NCH(NCH), .WIDTH(WIDTH), .DIV_W(DIV_W), .SET_W(SET_W)) bus ();

   sd_mag_scanner #(.NCH(NCH), .WIDTH(WIDTH), .DIV_W(DIV_W), .SET_W(SET_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIDTH-1:0] estFn(input int c);
      return WIDTH'(c * 40503 + 7);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Estimator output tracks the cycle index so each capture moment has a unique value.
   initial begin
      bus.est_out = '0;
      bus.sd_in   = '0;
      forever begin
         @(negedge clk);
         bus.est_out = estFn(cyc);
         #2 bus.sd_in = NCH'($urandom);
      end
   end

   task automatic applyStimulus(input logic [3:0] mask, input int d, input int s,
                                input int rMin, input int rMax, input int passes);
      int chList[$];
      int sEff, clearCyc, expValid, nEn, firstEn, lastEn, delay, lastPassFirst;
      logic seenValid;
      sEff = (s == 0) ? 1 : s;
      for (int p = 0; p < passes; p++)
         for (int c = 0; c < NCH; c++)
            if (mask[c]) chList.push_back(c);
      lastPassFirst = chList.size() - $countones(mask);
      @(negedge clk);
      bus.ch_mask    = mask;
      bus.div        = DIV_W'(d);
      bus.settle     = SET_W'(s);
      bus.continuous = (passes > 1);
      bus.start      = 1'b1;
      clearCyc       = cyc + 1;
      for (int k = 0; k < chList.size(); k++) begin
         delay     = $urandom_range(rMax, rMin);
         expValid  = clearCyc + 2 + sEff * (d + 1);
         nEn       = 0;
         firstEn   = -1;
         lastEn    = -1;
         seenValid = 1'b0;
         for (int t = 0; t < CYC_BUDGET && !seenValid; t++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.res_ready = (delay == 0);
            if ((passes > 1) && (k == lastPassFirst) && (cyc == clearCyc + 1)) bus.continuous = 1'b0;
            if (cyc == clearCyc) checkOutput("estRstClear", bus.est_rst, 1);
            checkOutput("busy", bus.busy, 1);
            checkOutput("estIn", bus.est_in, bus.sd_in[chList[k]]);
            if (bus.est_en) begin
               if (firstEn < 0) firstEn = cyc;
               lastEn = cyc;
               nEn++;
            end
            if (bus.res_valid) seenValid = 1'b1;
         end
         if (!seenValid) begin
            checkOutput("validTimeout", 0, 1);
            return;
         end
         checkOutput("validCycle", cyc, expValid);
         checkOutput("resCh", bus.res_ch, chList[k]);
         checkOutput("resMag", bus.res_mag, estFn(expValid - 1));
         checkOutput("enCount", nEn, sEff);
         checkOutput("firstEn", firstEn, clearCyc + 1 + d);
         checkOutput("lastEn", lastEn, expValid - 2);
         for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("holdEn", bus.est_en, 0);
            checkOutput("holdRst", bus.est_rst, 0);
            checkOutput("holdValid", bus.res_valid, 1);
            checkOutput("holdMag", bus.res_mag, estFn(expValid - 1));
            checkOutput("holdCh", bus.res_ch, chList[k]);
         end
         bus.res_ready = 1'b1;
         clearCyc = cyc + 1;
      end
      @(negedge clk);
      checkOutput("endBusy", bus.busy, 0);
      checkOutput("endValid", bus.res_valid, 0);
      checkOutput("endEstRst", bus.est_rst, 1);
      checkOutput("endEstIn", bus.est_in, 0);
   endtask

   task automatic abortTest(input logic inHold);
      logic seenValid;
      @(negedge clk);
      bus.ch_mask    = 4'b0110;
      bus.div        = DIV_W'(1);
      bus.settle     = SET_W'(3);
      bus.continuous = 1'b0;
      bus.res_ready  = 1'b0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (!inHold) begin
         repeat (3) @(negedge clk);
         checkOutput("abortPreBusy", bus.busy, 1);
      end else begin
         seenValid = 1'b0;
         for (int t = 0; t < CYC_BUDGET && !seenValid; t++) begin
            @(negedge clk);
            seenValid = bus.res_valid;
         end
         checkOutput("abortPreValid", seenValid, 1);
         bus.res_ready = 1'b1;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort     = 1'b0;
      bus.res_ready = 1'b0;
      checkOutput(inHold ? "abortHoldBusy" : "abortSettleBusy", bus.busy, 0);
      checkOutput(inHold ? "abortHoldValid" : "abortSettleValid", bus.res_valid, 0);
      checkOutput("abortEstRst", bus.est_rst, 1);
      checkOutput("abortEstEn", bus.est_en, 0);
      repeat (3) @(negedge clk);
      checkOutput("abortStaysIdle", bus.busy, 0);
   endtask

   task automatic idleTests();
      @(negedge clk);
      bus.ch_mask = 4'b0000;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("zeroMaskBusy", bus.busy, 0);
      bus.ch_mask = 4'b1111;
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checkOutput("startAbortBusy", bus.busy, 0);
      repeat (2) @(negedge clk);
      checkOutput("startAbortIdle", bus.busy, 0);
   endtask

   task automatic resetTest();
      @(negedge clk);
      bus.ch_mask   = 4'b1000;
      bus.div       = DIV_W'(2);
      bus.settle    = SET_W'(4);
      bus.res_ready = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("preResetBusy", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncEstRst", bus.est_rst, 1);
      checkOutput("asyncEstEn", bus.est_en, 0);
      checkOutput("asyncEstIn", bus.est_in, 0);
      checkOutput("asyncValid", bus.res_valid, 0);
      checkOutput("asyncResCh", bus.res_ch, 0);
      checkOutput("asyncResMag", bus.res_mag, 0);
      checkOutput("asyncBusy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.continuous = 1'b0;
      bus.ch_mask    = '0;
      bus.div        = '0;
      bus.settle     = '0;
      bus.res_ready  = 1'b0;
      #3;
      checkOutput("rstEstRst", bus.est_rst, 1);
      checkOutput("rstEstEn", bus.est_en, 0);
      checkOutput("rstEstIn", bus.est_in, 0);
      checkOutput("rstValid", bus.res_valid, 0);
      checkOutput("rstResCh", bus.res_ch, 0);
      checkOutput("rstResMag", bus.res_mag, 0);
      checkOutput("rstBusy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(4'b1011, 0, 1, 0, 0, 1);
      applyStimulus(4'b0100, 3, 5, 0, 0, 1);
      applyStimulus(4'b0010, 1, 2, 10, 10, 1);
      applyStimulus(4'b0100, 0, 2, 0, 1, 3);
      abortTest(1'b0);
      abortTest(1'b1);
      idleTests();
      resetTest();
      applyStimulus(4'b1111, 0, 0, 0, 0, 1);
      for (int r = 0; r < 10; r++) begin
         applyStimulus(4'($urandom_range(15, 1)), $urandom_range(3, 0), $urandom_range(4, 0),
                       0, $urandom_range(3, 0), $urandom_range(2, 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
